// File: rtl/mac_tx_arbiter_if.sv
// Requester, MAC transmit and status signals of the two-requester MAC TX arbiter.
// slave is the arbiter side; master is the requesters/MAC side.
interface mac_tx_arbiter_if;
   logic [7:0]  req0_data;
   logic        req0_sop;
   logic        req0_eop;
   logic        req0_err;
   logic        req0_valid;
   logic        req0_rdy;
   logic [7:0]  req1_data;
   logic        req1_sop;
   logic        req1_eop;
   logic        req1_err;
   logic        req1_valid;
   logic        req1_rdy;
   logic [7:0]  tx_data;
   logic        tx_sop;
   logic        tx_eop;
   logic        tx_err;
   logic        tx_wren;
   logic        tx_rdy;
   logic [1:0]  grant;
   logic [15:0] frames_sent;
   logic [7:0]  frames_trunc;

   modport slave (
      input  req0_data, req0_sop, req0_eop, req0_err, req0_valid,
      input  req1_data, req1_sop, req1_eop, req1_err, req1_valid,
      output req0_rdy, req1_rdy,
      output tx_data, tx_sop, tx_eop, tx_err, tx_wren,
      input  tx_rdy,
      output grant, frames_sent, frames_trunc
   );

   modport master (
      output req0_data, req0_sop, req0_eop, req0_err, req0_valid,
      output req1_data, req1_sop, req1_eop, req1_err, req1_valid,
      input  req0_rdy, req1_rdy,
      input  tx_data, tx_sop, tx_eop, tx_err, tx_wren,
      output tx_rdy,
      input  grant, frames_sent, frames_trunc
   );
endinterface

// File: rtl/mac_tx_arbiter.sv
// Two-requester frame arbiter feeding a MAC transmit port; whole frames only,
// round-robin on ties, truncation of frames longer than MAX_LEN.
module mac_tx_arbiter #(
   parameter int unsigned MAX_LEN = 1518
) (
   input logic           tx_clk,
   input logic           rst,
   mac_tx_arbiter_if.slave bus
);

   localparam int unsigned CW = ($clog2(MAX_LEN + 1) > 11) ? $clog2(MAX_LEN + 1) : 11;
   localparam logic [CW-1:0] LAST_IDX = CW'(MAX_LEN - 1);

   typedef enum logic [1:0] {IDLE, XFER, DRAIN} state_t;

   state_t        state, state_nxt;
   logic          owner, owner_nxt;
   logic          last_owner, last_owner_nxt;
   logic [CW-1:0] byte_cnt, byte_cnt_nxt;
   logic [15:0]   sent, sent_nxt;
   logic [7:0]    trunc, trunc_nxt;

   logic [7:0] own_data;
   logic       own_sop, own_eop, own_err, own_valid;
   logic       cand0, cand1;

   assign own_data  = owner ? bus.req1_data  : bus.req0_data;
   assign own_sop   = owner ? bus.req1_sop   : bus.req0_sop;
   assign own_eop   = owner ? bus.req1_eop   : bus.req0_eop;
   assign own_err   = owner ? bus.req1_err   : bus.req0_err;
   assign own_valid = owner ? bus.req1_valid : bus.req0_valid;

   assign cand0 = bus.req0_valid & bus.req0_sop;
   assign cand1 = bus.req1_valid & bus.req1_sop;

   assign bus.frames_sent  = sent;
   assign bus.frames_trunc = trunc;

   always_ff @(posedge tx_clk) begin
      if (rst) begin
         state      <= IDLE;
         owner      <= 1'b0;
         last_owner <= 1'b1;
         byte_cnt   <= '0;
         sent       <= '0;
         trunc      <= '0;
      end else begin
         state      <= state_nxt;
         owner      <= owner_nxt;
         last_owner <= last_owner_nxt;
         byte_cnt   <= byte_cnt_nxt;
         sent       <= sent_nxt;
         trunc      <= trunc_nxt;
      end
   end

   // Outputs are gated by rst so nothing is offered or accepted while reset is held.
   always_comb begin
      state_nxt      = state;
      owner_nxt      = owner;
      last_owner_nxt = last_owner;
      byte_cnt_nxt   = byte_cnt;
      sent_nxt       = sent;
      trunc_nxt      = trunc;
      bus.req0_rdy   = 1'b0;
      bus.req1_rdy   = 1'b0;
      bus.tx_data    = '0;
      bus.tx_sop     = 1'b0;
      bus.tx_eop     = 1'b0;
      bus.tx_err     = 1'b0;
      bus.tx_wren    = 1'b0;
      bus.grant      = '0;

      if (!rst) begin
         unique case (state)
            IDLE: begin
               bus.req0_rdy = bus.req0_valid & ~bus.req0_sop;
               bus.req1_rdy = bus.req1_valid & ~bus.req1_sop;
               if (cand0 | cand1) begin
                  owner_nxt    = (cand0 & cand1) ? ~last_owner : cand1;
                  byte_cnt_nxt = '0;
                  state_nxt    = XFER;
               end
            end

            XFER: begin
               bus.grant   = owner ? 2'b10 : 2'b01;
               bus.tx_data = own_data;
               bus.tx_sop  = own_sop;
               bus.tx_eop  = own_eop;
               bus.tx_err  = own_err;
               bus.tx_wren = own_valid & bus.tx_rdy;
               if (owner) bus.req1_rdy = bus.tx_rdy;
               else       bus.req0_rdy = bus.tx_rdy;
               if (own_valid & bus.tx_rdy) begin
                  byte_cnt_nxt = byte_cnt + CW'(1);
                  if (own_eop) begin
                     sent_nxt       = sent + 16'd1;
                     last_owner_nxt = owner;
                     state_nxt      = IDLE;
                  end else if (byte_cnt == LAST_IDX) begin
                     // Close the frame on the MAC side and swallow the rest of it.
                     bus.tx_eop     = 1'b1;
                     bus.tx_err     = 1'b1;
                     trunc_nxt      = (trunc == 8'hFF) ? trunc : trunc + 8'd1;
                     sent_nxt       = sent + 16'd1;
                     last_owner_nxt = owner;
                     state_nxt      = DRAIN;
                  end
               end
            end

            DRAIN: begin
               bus.grant = owner ? 2'b10 : 2'b01;
               if (owner) bus.req1_rdy = 1'b1;
               else       bus.req0_rdy = 1'b1;
               if (own_valid & own_eop) state_nxt = IDLE;
            end

            default: state_nxt = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// Directed bench for mac_tx_arbiter: default-length instance plus a MAX_LEN=16
// instance for truncation.
module tb_mac_tx_arbiter;

   logic tx_clk = 1'b0;
   logic rst    = 1'b1;

   always #5 tx_clk = ~tx_clk;

   mac_tx_arbiter_if bus ();
   mac_tx_arbiter_if bus16 ();

   mac_tx_arbiter dut (.tx_clk(tx_clk), .rst(rst), .bus(bus));
   mac_tx_arbiter #(.MAX_LEN(16)) dut16 (.tx_clk(tx_clk), .rst(rst), .bus(bus16));

   int tests = 0;
   int fails = 0;
   int exp_sent = 0;

   logic [10:0] cap0[$];
   logic [10:0] cap16[$];
   logic [1:0]  glog[$];
   logic [1:0]  prev_grant = 2'b00;

   always @(negedge tx_clk) begin
      if (bus.tx_wren)   cap0.push_back({bus.tx_err, bus.tx_eop, bus.tx_sop, bus.tx_data});
      if (bus16.tx_wren) cap16.push_back({bus16.tx_err, bus16.tx_eop, bus16.tx_sop, bus16.tx_data});
      if (bus.grant != 2'b00 && prev_grant == 2'b00) glog.push_back(bus.grant);
      prev_grant = bus.grant;
   end

   task automatic set_req(input int b, input int r, input logic [7:0] d,
                          input logic s, input logic e, input logic er, input logic v);
      if (b == 0 && r == 0) begin
         bus.req0_data = d; bus.req0_sop = s; bus.req0_eop = e; bus.req0_err = er; bus.req0_valid = v;
      end else if (b == 0) begin
         bus.req1_data = d; bus.req1_sop = s; bus.req1_eop = e; bus.req1_err = er; bus.req1_valid = v;
      end else if (r == 0) begin
         bus16.req0_data = d; bus16.req0_sop = s; bus16.req0_eop = e; bus16.req0_err = er; bus16.req0_valid = v;
      end else begin
         bus16.req1_data = d; bus16.req1_sop = s; bus16.req1_eop = e; bus16.req1_err = er; bus16.req1_valid = v;
      end
   endtask

   function automatic logic get_rdy(input int b, input int r);
      if (b == 0) return (r == 0) ? bus.req0_rdy : bus.req1_rdy;
      return (r == 0) ? bus16.req0_rdy : bus16.req1_rdy;
   endfunction

   // Offers len bytes base+i, holding each until accepted; first_wait = edges for byte 0.
   task automatic send(input int b, input int r, input int len, input logic [7:0] base,
                       input bit with_sop, output int first_wait, output bit ok);
      ok = 1'b1;
      first_wait = 0;
      for (int i = 0; i < len; i++) begin
         int guard;
         bit acc;
         guard = 0;
         acc = 1'b0;
         set_req(b, r, base + 8'(i), with_sop && (i == 0), i == len - 1, 1'b0, 1'b1);
         while (!acc && guard < 500) begin
            @(negedge tx_clk);
            acc = get_rdy(b, r);
            @(posedge tx_clk); #1;
            guard++;
         end
         if (i == 0) first_wait = guard;
         if (!acc) begin
            ok = 1'b0;
            break;
         end
      end
      set_req(b, r, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      bus.tx_rdy = 1'b1;
      bus16.tx_rdy = 1'b1;
      for (int b = 0; b < 2; b++)
         for (int r = 0; r < 2; r++) set_req(b, r, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (3) @(posedge tx_clk);
      #1;
      set_req(0, 0, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1);
      @(negedge tx_clk);
      tests++; if (bus.grant !== 2'b00) begin fails++; $display("FAIL reset_grant got=%b exp=00", bus.grant); end
      tests++; if (bus.frames_sent !== 16'd0) begin fails++; $display("FAIL reset_sent got=%0d exp=0", bus.frames_sent); end
      tests++; if (bus.frames_trunc !== 8'd0) begin fails++; $display("FAIL reset_trunc got=%0d exp=0", bus.frames_trunc); end
      tests++; if (bus.tx_wren !== 1'b0) begin fails++; $display("FAIL reset_wren got=%b exp=0", bus.tx_wren); end
      tests++; if (bus.req0_rdy !== 1'b0 || bus.req1_rdy !== 1'b0) begin
         fails++; $display("FAIL reset_rdy got=%b%b exp=00", bus.req0_rdy, bus.req1_rdy); end
      tests++; if ({bus.tx_data, bus.tx_sop, bus.tx_eop, bus.tx_err} !== 11'd0) begin
         fails++; $display("FAIL reset_txout got=%h exp=0", {bus.tx_data, bus.tx_sop, bus.tx_eop, bus.tx_err}); end
      @(posedge tx_clk); #1;
      set_req(0, 0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      @(negedge tx_clk);
      tests++; if ({bus.tx_data, bus.tx_sop, bus.tx_eop, bus.tx_err, bus.grant} !== 13'd0) begin
         fails++; $display("FAIL post_reset_idle got=%h exp=0", {bus.tx_data, bus.tx_sop, bus.tx_eop, bus.tx_err, bus.grant}); end
      @(posedge tx_clk); #1;
   endtask

   task automatic test_simultaneous;
      int s, g, fw0, fw1;
      bit ok0, ok1;
      logic [10:0] exp;
      s = cap0.size();
      g = glog.size();
      fork
         send(0, 0, 64, 8'h00, 1'b1, fw0, ok0);
         send(0, 1, 64, 8'h80, 1'b1, fw1, ok1);
      join
      repeat (3) @(posedge tx_clk);
      #1;
      exp_sent += 2;
      tests++; if (ok0 !== 1'b1 || ok1 !== 1'b1) begin fails++; $display("FAIL sim_timeout got=%b%b exp=11", ok0, ok1); end
      tests++; if (fw0 !== 2) begin fails++; $display("FAIL sim_first_latency got=%0d exp=2", fw0); end
      tests++; if (cap0.size() - s !== 128) begin fails++; $display("FAIL sim_bytecount got=%0d exp=128", cap0.size() - s); end
      if (cap0.size() - s >= 128) begin
         for (int i = 0; i < 128; i++) begin
            exp = {1'b0, (i % 64) == 63, (i % 64) == 0, ((i < 64) ? 8'h00 : 8'h80) + 8'(i % 64)};
            tests++; if (cap0[s + i] !== exp) begin fails++; $display("FAIL sim_byte%0d got=%h exp=%h", i, cap0[s + i], exp); end
         end
      end
      tests++; if (glog.size() - g !== 2) begin fails++; $display("FAIL sim_grants got=%0d exp=2", glog.size() - g); end
      else begin
         tests++; if (glog[g] !== 2'b01 || glog[g + 1] !== 2'b10) begin
            fails++; $display("FAIL sim_grant_order got=%b,%b exp=01,10", glog[g], glog[g + 1]); end
      end
      tests++; if (bus.frames_sent !== 16'(exp_sent)) begin fails++; $display("FAIL sim_sent got=%0d exp=%0d", bus.frames_sent, exp_sent); end
   endtask

   task automatic test_back_to_back;
      int s, g, fwa, fwb;
      bit oka, okb;
      logic [1:0] exp_g[5];
      logic [7:0] exp_b[5];
      exp_g = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
      exp_b = '{8'h10, 8'h90, 8'h20, 8'hA0, 8'h30};
      s = cap0.size();
      g = glog.size();
      oka = 1'b1;
      okb = 1'b1;
      fork
         begin
            bit k_ok;
            for (int k = 0; k < 3; k++) begin
               send(0, 0, 4, 8'h10 + 8'(16 * k), 1'b1, fwa, k_ok);
               oka &= k_ok;
            end
         end
         begin
            bit k_ok;
            for (int k = 0; k < 2; k++) begin
               send(0, 1, 4, 8'h90 + 8'(16 * k), 1'b1, fwb, k_ok);
               okb &= k_ok;
            end
         end
      join
      repeat (3) @(posedge tx_clk);
      #1;
      exp_sent += 5;
      tests++; if (oka !== 1'b1 || okb !== 1'b1) begin fails++; $display("FAIL b2b_timeout got=%b%b exp=11", oka, okb); end
      tests++; if (glog.size() - g !== 5) begin fails++; $display("FAIL b2b_grants got=%0d exp=5", glog.size() - g); end
      else begin
         for (int i = 0; i < 5; i++) begin
            tests++; if (glog[g + i] !== exp_g[i]) begin fails++; $display("FAIL b2b_grant%0d got=%b exp=%b", i, glog[g + i], exp_g[i]); end
         end
      end
      tests++; if (cap0.size() - s !== 20) begin fails++; $display("FAIL b2b_bytecount got=%0d exp=20", cap0.size() - s); end
      else begin
         for (int f = 0; f < 5; f++) begin
            tests++; if (cap0[s + 4 * f] !== {3'b001, exp_b[f]}) begin
               fails++; $display("FAIL b2b_frame%0d_sop got=%h exp=%h", f, cap0[s + 4 * f], {3'b001, exp_b[f]}); end
         end
      end
      tests++; if (bus.frames_sent !== 16'(exp_sent)) begin fails++; $display("FAIL b2b_sent got=%0d exp=%0d", bus.frames_sent, exp_sent); end
   endtask

   task automatic test_truncation;
      int s, fw;
      bit ok;
      logic [10:0] exp;
      s = cap16.size();
      send(1, 1, 40, 8'h40, 1'b1, fw, ok);
      repeat (2) @(posedge tx_clk);
      #1;
      tests++; if (ok !== 1'b1) begin fails++; $display("FAIL trunc_drain_timeout got=%b exp=1", ok); end
      tests++; if (cap16.size() - s !== 16) begin fails++; $display("FAIL trunc_bytecount got=%0d exp=16", cap16.size() - s); end
      else begin
         for (int i = 0; i < 16; i++) begin
            exp = {i == 15, i == 15, i == 0, 8'h40 + 8'(i)};
            tests++; if (cap16[s + i] !== exp) begin fails++; $display("FAIL trunc_byte%0d got=%h exp=%h", i, cap16[s + i], exp); end
         end
      end
      tests++; if (bus16.frames_trunc !== 8'd1) begin fails++; $display("FAIL trunc_count got=%0d exp=1", bus16.frames_trunc); end
      tests++; if (bus16.frames_sent !== 16'd1) begin fails++; $display("FAIL trunc_sent got=%0d exp=1", bus16.frames_sent); end
      tests++; if (bus16.grant !== 2'b00) begin fails++; $display("FAIL trunc_idle_grant got=%b exp=00", bus16.grant); end

      // Exactly MAX_LEN bytes: ends on its own eop, no truncation.
      s = cap16.size();
      send(1, 0, 16, 8'h60, 1'b1, fw, ok);
      repeat (2) @(posedge tx_clk);
      #1;
      tests++; if (cap16.size() - s !== 16) begin fails++; $display("FAIL maxlen_bytecount got=%0d exp=16", cap16.size() - s); end
      else begin
         tests++; if (cap16[s + 15] !== {3'b010, 8'h6F}) begin
            fails++; $display("FAIL maxlen_last got=%h exp=%h", cap16[s + 15], {3'b010, 8'h6F}); end
      end
      tests++; if (bus16.frames_trunc !== 8'd1) begin fails++; $display("FAIL maxlen_trunc got=%0d exp=1", bus16.frames_trunc); end
      tests++; if (bus16.frames_sent !== 16'd2) begin fails++; $display("FAIL maxlen_sent got=%0d exp=2", bus16.frames_sent); end
   endtask

   task automatic test_random_rdy;
      int s, fw;
      bit ok, done;
      logic [10:0] exp;
      s = cap0.size();
      done = 1'b0;
      fork
         begin
            send(0, 1, 100, 8'h20, 1'b1, fw, ok);
            done = 1'b1;
         end
         begin
            while (!done) begin
               bus.tx_rdy = 1'($urandom_range(0, 1));
               @(posedge tx_clk); #1;
            end
         end
      join
      bus.tx_rdy = 1'b1;
      repeat (2) @(posedge tx_clk);
      #1;
      exp_sent += 1;
      tests++; if (ok !== 1'b1) begin fails++; $display("FAIL rnd_timeout got=%b exp=1", ok); end
      tests++; if (cap0.size() - s !== 100) begin fails++; $display("FAIL rnd_bytecount got=%0d exp=100", cap0.size() - s); end
      else begin
         for (int i = 0; i < 100; i++) begin
            exp = {1'b0, i == 99, i == 0, 8'h20 + 8'(i)};
            tests++; if (cap0[s + i] !== exp) begin fails++; $display("FAIL rnd_byte%0d got=%h exp=%h", i, cap0[s + i], exp); end
         end
      end
      tests++; if (bus.frames_sent !== 16'(exp_sent)) begin fails++; $display("FAIL rnd_sent got=%0d exp=%0d", bus.frames_sent, exp_sent); end
   endtask

   task automatic test_misaligned;
      int s, fw;
      bit ok;
      s = cap0.size();
      send(0, 0, 5, 8'hA0, 1'b0, fw, ok);
      tests++; if (ok !== 1'b1) begin fails++; $display("FAIL mis_consume got=%b exp=1", ok); end
      tests++; if (fw !== 1) begin fails++; $display("FAIL mis_immediate_rdy got=%0d exp=1", fw); end
      tests++; if (cap0.size() - s !== 0) begin fails++; $display("FAIL mis_no_write got=%0d exp=0", cap0.size() - s); end
      send(0, 0, 4, 8'hB0, 1'b1, fw, ok);
      repeat (2) @(posedge tx_clk);
      #1;
      exp_sent += 1;
      tests++; if (fw !== 2) begin fails++; $display("FAIL mis_next_latency got=%0d exp=2", fw); end
      tests++; if (cap0.size() - s !== 4) begin fails++; $display("FAIL mis_next_count got=%0d exp=4", cap0.size() - s); end
      else begin
         tests++; if (cap0[s] !== {3'b001, 8'hB0} || cap0[s + 3] !== {3'b010, 8'hB3}) begin
            fails++; $display("FAIL mis_next_frame got=%h,%h exp=%h,%h", cap0[s], cap0[s + 3], {3'b001, 8'hB0}, {3'b010, 8'hB3}); end
      end
      tests++; if (bus.frames_sent !== 16'(exp_sent)) begin fails++; $display("FAIL mis_sent got=%0d exp=%0d", bus.frames_sent, exp_sent); end
   endtask

   task automatic test_reset_midframe;
      int s, fw, guard;
      bit ok, acc, all_ok;
      all_ok = 1'b1;
      for (int i = 0; i < 20; i++) begin
         set_req(0, 0, 8'h00 + 8'(i), i == 0, 1'b0, 1'b0, 1'b1);
         guard = 0;
         acc = 1'b0;
         while (!acc && guard < 500) begin
            @(negedge tx_clk);
            acc = bus.req0_rdy;
            @(posedge tx_clk); #1;
            guard++;
         end
         all_ok &= acc;
      end
      tests++; if (all_ok !== 1'b1) begin fails++; $display("FAIL rstmid_prefix got=%b exp=1", all_ok); end
      set_req(0, 0, 8'd20, 1'b0, 1'b0, 1'b0, 1'b1);
      rst = 1'b1;
      @(negedge tx_clk);
      tests++; if (bus.tx_wren !== 1'b0 || bus.req0_rdy !== 1'b0) begin
         fails++; $display("FAIL rstmid_during got=wren%b rdy%b exp=00", bus.tx_wren, bus.req0_rdy); end
      @(posedge tx_clk); #1;
      rst = 1'b0;
      set_req(0, 0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      exp_sent = 0;
      @(negedge tx_clk);
      tests++; if (bus.grant !== 2'b00) begin fails++; $display("FAIL rstmid_grant got=%b exp=00", bus.grant); end
      tests++; if (bus.frames_sent !== 16'd0 || bus.frames_trunc !== 8'd0) begin
         fails++; $display("FAIL rstmid_counters got=%0d/%0d exp=0/0", bus.frames_sent, bus.frames_trunc); end
      tests++; if (bus16.frames_sent !== 16'd0 || bus16.frames_trunc !== 8'd0) begin
         fails++; $display("FAIL rstmid_counters16 got=%0d/%0d exp=0/0", bus16.frames_sent, bus16.frames_trunc); end
      @(posedge tx_clk); #1;
      s = cap0.size();
      send(0, 0, 3, 8'hD0, 1'b1, fw, ok);
      repeat (2) @(posedge tx_clk);
      #1;
      exp_sent += 1;
      tests++; if (cap0.size() - s !== 3) begin fails++; $display("FAIL rstmid_new_count got=%0d exp=3", cap0.size() - s); end
      else begin
         tests++; if (cap0[s] !== {3'b001, 8'hD0} || cap0[s + 1] !== {3'b000, 8'hD1} || cap0[s + 2] !== {3'b010, 8'hD2}) begin
            fails++; $display("FAIL rstmid_new_frame got=%h,%h,%h exp=1d0,0d1,2d2", cap0[s], cap0[s + 1], cap0[s + 2]); end
      end
      tests++; if (bus.frames_sent !== 16'(exp_sent)) begin fails++; $display("FAIL rstmid_sent got=%0d exp=%0d", bus.frames_sent, exp_sent); end
   endtask

   initial begin
      test_reset();
      test_simultaneous();
      test_back_to_back();
      test_truncation();
      test_random_rdy();
      test_misaligned();
      test_reset_midframe();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
